spi_master_ctl: RTL
===================

// Module: spi_master_ctl
// PURPOSE
//  Byte-level SPI master engine. Sits directly upstream of the USB/SPI pin mux on CLK24.
//  Drives the mux's spi_* control/data inputs and samples its spi_*_i returns.
//  Turns a byte command stream into SPI mode-0 frames (CPOL=0, CPHA=0, MSB first, CS active low).
//  Returns one received byte per transmitted byte.
// PARAMETERS
//  DIV        2  CLK24 cycles per SCK half-period (>=1); 2 -> 6 MHz SCK
//  CS_SETUP   2  CLK24 cycles from CS low to first SCK rise edge window start
//  CS_HOLD    2  CLK24 cycles from last SCK fall to CS high
// PORTS
//  CLK24      in   1  system clock, 24 MHz
//  RST        in   1  asynchronous active-high reset
//  ctl_en     in   1  request ownership of the shared pins
//  cmd_valid  in   1  command byte available
//  cmd_ready  out  1  engine accepts command this cycle
//  cmd_data   in   8  byte to shift out
//  cmd_last   in   1  deassert CS after this byte
//  cmd_dual   in   1  dual-read byte (used only with SPI_DUAL_RD_EN)
//  rsp_valid  out  1  one-cycle pulse, rsp_data valid
//  rsp_data   out  8  byte shifted in
//  busy       out  1  state != IDLE
//  spi_en, spi_clk_o, spi_sel_o, spi_do_en, spi_do_o, spi_di_en, spi_di_o  out 1  to pin mux
//  spi_do_i, spi_di_i  in  1  from pin mux (spi_di_i = MISO)
// BEHAVIOUR
//  Reset values: spi_en=0, spi_clk_o=0, spi_sel_o=1, spi_do_en=0, spi_do_o=0, spi_di_en=0,
//    spi_di_o=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0. All outputs are registered.
//  States:
//  - IDLE:
//    - cmd_ready = ctl_en.
//    - On cmd_valid & cmd_ready: latch data/last/dual into the shift register and go to SETUP.
//  - SETUP: spi_sel_o=0. Count CS_SETUP cycles -> SHIFT.
//  - SHIFT: 8 bit-cells, each 2*DIV cycles: SCK low for DIV cycles, then high for DIV cycles.
//    - spi_do_o presents the MSB while SCK is low.
//    - spi_di_i is sampled on the CLK24 edge that raises SCK.
//    - The register shifts left on SCK fall.
//  - NEXT (1 cycle):
//    - rsp_valid=1 with the byte.
//    - If !last, cmd_ready=1. If cmd_valid, reload -> SHIFT with no CS gap.
//    - Else stay in NEXT with CS low and SCK low.
//  - HOLD: count CS_HOLD cycles, then spi_sel_o=1 -> IDLE.
//  Byte latency: accept -> rsp_valid = CS_SETUP + 16*DIV + 1 cycles (first byte of a frame).
//  Pin ownership:
//  - spi_en = ctl_en | busy.
//  - spi_do_en = spi_en (MOSI driven). spi_di_en=0, spi_di_o=0.
//  - Dropping ctl_en mid-frame has no effect until the frame ends with cmd_last; then spi_en falls.
//  cmd_ready is never asserted in SETUP, SHIFT or HOLD.
//  Asynchronous RST mid-byte aborts: outputs go to reset values immediately and no rsp is produced.
// CONFIGURATION
//  SPI_DUAL_RD_EN defined:
//  - When the latched cmd_dual=1, spi_do_en=0 for the byte.
//  - Each bit-cell samples {spi_do_i, spi_di_i} as 2 bits (do_i = higher bit).
//  - 4 cells per byte; latency CS_SETUP + 8*DIV + 1.
//  SPI_DUAL_RD_EN undefined:
//  - cmd_dual is ignored and all bytes are single-bit.
//  - spi_do_en = spi_en always.
// STRUCTURE
//  Shared include spi_usb_defs.vh: state encodings (IDLE/SETUP/SHIFT/NEXT/HOLD) and the default
//    DIV/CS timing constants.
//  One sub-module, spi_clk_div: DIV half-period counter producing rise/fall ticks.
//    Cleared while not in SHIFT.
// TESTING
//  1. DIV=2, send 0xA5 with last=1, MISO tied to pattern 0x3C:
//     - spi_do_o sequence 1,0,1,0,0,1,0,1.
//     - rsp_data=0x3C.
//     - rsp_valid at cycle 35 after accept; CS low for 2+32+1+2 cycles.
//  2. Back-to-back 0x9F (last=0) then 0x00 (last=1):
//     - CS stays low across both bytes.
//     - Two rsp pulses 33 cycles apart; single HOLD.
//  3. Stall in NEXT (cmd_valid low 10 cycles, then 0x55 last=1):
//     - SCK stays 0 and CS stays 0 during the stall.
//     - The frame then completes normally.
//  4. ctl_en=0 at idle: cmd_valid=1 -> cmd_ready=0, spi_en=0, spi_sel_o=1. Raise ctl_en -> accepted.
//  5. RST pulse during bit 4 of a byte:
//     - Same cycle: spi_sel_o=1, spi_clk_o=0, spi_en=0.
//     - No rsp_valid; next command runs cleanly.
//  6. (SPI_DUAL_RD_EN) cmd_dual=1, do_i/di_i driving bits of 0xB4:
//     - spi_do_en=0 for the byte.
//     - rsp_data=0xB4 after 4 cells (latency 19 at DIV=2).

Source files
------------

// File: rtl/spi_master_ctl_pkg.sv
// Shared state encoding and default timing constants for the spi_master_ctl engine.
package spi_master_ctl_pkg;

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StNext, StHold} state_e;

  localparam int unsigned DefDiv     = 2;
  localparam int unsigned DefCsSetup = 2;
  localparam int unsigned DefCsHold  = 2;
  localparam int unsigned CntW       = 8;

  // Index of the final bit-cell in a byte; dual reads move two bits per cell.
  function automatic logic [2:0] last_cell(input logic dual);
    return dual ? 3'd3 : 3'd7;
  endfunction

endpackage

// File: rtl/spi_master_ctl_if.sv
// Command/response stream plus pin-mux signals of the SPI master engine.
// The engine uses the slave modport; the command source uses the master modport.
interface spi_master_ctl_if;
  logic       ctl_en;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       cmd_last;
  logic       cmd_dual;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       spi_en;
  logic       spi_clk_o;
  logic       spi_sel_o;
  logic       spi_do_en;
  logic       spi_do_o;
  logic       spi_di_en;
  logic       spi_di_o;
  logic       spi_do_i;
  logic       spi_di_i;

  modport master (
    output ctl_en, cmd_valid, cmd_data, cmd_last, cmd_dual, spi_do_i, spi_di_i,
    input  cmd_ready, rsp_valid, rsp_data, busy,
    input  spi_en, spi_clk_o, spi_sel_o, spi_do_en, spi_do_o, spi_di_en, spi_di_o
  );

  modport slave (
    input  ctl_en, cmd_valid, cmd_data, cmd_last, cmd_dual, spi_do_i, spi_di_i,
    output cmd_ready, rsp_valid, rsp_data, busy,
    output spi_en, spi_clk_o, spi_sel_o, spi_do_en, spi_do_o, spi_di_en, spi_di_o
  );
endinterface

// File: rtl/spi_master_ctl_clk_div.sv
// SCK half-period timer: flags a rise or fall every DIV cycles while not cleared.
module spi_master_ctl_clk_div #(
  parameter int unsigned DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic rise_o,
  output logic fall_o
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          tick;

  assign tick   = (cnt_q == CW'(DIV - 1));
  assign rise_o = tick & ~phase_q & ~clear_i;
  assign fall_o = tick & phase_q & ~clear_i;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clear_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_master_ctl.sv
// Byte-level SPI mode-0 master feeding the USB/SPI pin mux; one response byte per byte sent.
// Dual-bit reads (do_i/di_i per cell) are compiled in when SPI_DUAL_RD_EN is defined.
module spi_master_ctl
  import spi_master_ctl_pkg::*;
#(
  parameter int unsigned DIV      = DefDiv,
  parameter int unsigned CS_SETUP = DefCsSetup,
  parameter int unsigned CS_HOLD  = DefCsHold
) (
  input logic             CLK24,
  input logic             RST,
  spi_master_ctl_if.slave bus
);
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      cell_q, cell_d;
  logic [7:0]      tx_q, tx_d, rx_q, rx_d, rx_shift;
  logic            last_q, last_d, dual_q, dual_d, dual_cmd;
  logic            rise, fall, accept;
  logic            ready_q, ready_d, rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            busy_q, busy_d, en_q, en_d, sck_q, sck_d, sel_q, sel_d;
  logic            do_en_q, do_en_d, do_q, do_d;

`ifdef SPI_DUAL_RD_EN
  assign rx_shift = dual_q ? {rx_q[5:0], bus.spi_do_i, bus.spi_di_i} : {rx_q[6:0], bus.spi_di_i};
  assign dual_cmd = bus.cmd_dual;
`else
  assign rx_shift = {rx_q[6:0], bus.spi_di_i};
  assign dual_cmd = 1'b0;
`endif

  spi_master_ctl_clk_div #(
    .DIV(DIV)
  ) u_clk_div (
    .clk_i  (CLK24),
    .rst_i  (RST),
    .clear_i(state_q != StShift),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cell_d      = cell_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    last_d      = last_q;
    dual_d      = dual_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    accept      = 1'b0;

    unique case (state_q)
      StIdle: accept = ready_q & bus.cmd_valid;
      StSetup: begin
        if (cnt_q == CntW'(CS_SETUP - 1)) state_d = StShift;
        else cnt_d = cnt_q + 1'b1;
      end
      StShift: begin
        if (rise) rx_d = rx_shift;
        if (fall) begin
          tx_d = {tx_q[6:0], 1'b0};
          if (cell_q == last_cell(dual_q)) begin
            state_d     = StNext;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_q;
          end else begin
            cell_d = cell_q + 3'd1;
          end
        end
      end
      StNext: begin
        // Without cmd_last the frame parks here, CS low, until the next byte arrives.
        if (last_q) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          accept = ready_q & bus.cmd_valid;
        end
      end
      StHold: begin
        if (cnt_q == CntW'(CS_HOLD - 1)) state_d = StIdle;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d = (state_q == StIdle) ? StSetup : StShift;
      tx_d    = bus.cmd_data;
      last_d  = bus.cmd_last;
      dual_d  = dual_cmd;
      cell_d  = '0;
      cnt_d   = '0;
    end
  end

  // Outputs are registered from next-state so they line up with the state register.
  always_comb begin
    busy_d  = (state_d != StIdle);
    en_d    = bus.ctl_en | busy_d;
    ready_d = ((state_d == StIdle) & bus.ctl_en) | ((state_d == StNext) & ~last_d);
    sel_d   = (state_d == StIdle);
    sck_d   = 1'b0;
    if (state_d == StShift) sck_d = rise | (sck_q & ~fall);
    do_d    = (state_d == StShift) ? tx_d[7] : 1'b0;
    do_en_d = en_d & ~(dual_d & ((state_d == StSetup) | (state_d == StShift)));
  end

  always_ff @(posedge CLK24 or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cell_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      last_q      <= 1'b0;
      dual_q      <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      en_q        <= 1'b0;
      sck_q       <= 1'b0;
      sel_q       <= 1'b1;
      do_en_q     <= 1'b0;
      do_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cell_q      <= cell_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      last_q      <= last_d;
      dual_q      <= dual_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      en_q        <= en_d;
      sck_q       <= sck_d;
      sel_q       <= sel_d;
      do_en_q     <= do_en_d;
      do_q        <= do_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;
  assign bus.spi_en    = en_q;
  assign bus.spi_clk_o = sck_q;
  assign bus.spi_sel_o = sel_q;
  assign bus.spi_do_en = do_en_q;
  assign bus.spi_do_o  = do_q;
  assign bus.spi_di_en = 1'b0;
  assign bus.spi_di_o  = 1'b0;

endmodule
